// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: source select encoding and the
// stored result/flags entry.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        SEL_BOOL  = 2'b00,
        SEL_ARITH = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_CMP   = 2'b11
    } unit_sel_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
        logic carry;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        alu_flags_t           flags;
    } alu_entry_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO of alu_entry_t; in_ready depends only on the count register,
// so there is no combinational path from out_ready back to in_ready.
module result_fifo2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  alu_entry_t wr_data,
    output logic       out_valid,
    input  logic       out_ready,
    output alu_entry_t rd_data
);

    alu_entry_t mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; the head is masked so outputs read zero when empty.
    assign rd_data = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects one functional unit's result, derives flags,
// buffers through a 2-entry FIFO and counts back-pressure cycles.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = ALU_WIDTH,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             unit_sel,
    input  logic [WIDTH-1:0]       bool_in,
    input  logic [WIDTH-1:0]       arith_in,
    input  logic                   arith_ovf,
    input  logic                   arith_cout,
    input  logic [WIDTH-1:0]       shift_in,
    input  logic                   cmp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       result,
    output logic                   zero,
    output logic                   negative,
    output logic                   overflow,
    output logic                   carry,
    input  logic                   stat_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [WIDTH-1:0] sel_result;
    alu_entry_t       wr_entry;
    alu_entry_t       head;

    always_comb begin
        sel_result        = '0;
        wr_entry          = '0;
        case (unit_sel_e'(unit_sel))
            SEL_BOOL:  sel_result = bool_in;
            SEL_ARITH: begin
                sel_result              = arith_in;
                wr_entry.flags.overflow = arith_ovf;
                wr_entry.flags.carry    = arith_cout;
            end
            SEL_SHIFT: sel_result = shift_in;
            SEL_CMP:   sel_result = {{(WIDTH-1){1'b0}}, cmp_in};
            default:   sel_result = '0;
        endcase
        wr_entry.result         = sel_result;
        wr_entry.flags.zero     = (sel_result == '0);
        wr_entry.flags.negative = sel_result[WIDTH-1];
    end

    result_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_data   (wr_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_data   (head)
    );

    assign result   = head.result;
    assign zero     = head.flags.zero;
    assign negative = head.flags.negative;
    assign overflow = head.flags.overflow;
    assign carry    = head.flags.carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU functional units: boolean unit, add/sub unit, shifter and set-less-than comparator.
- Selects one unit's result per operation, derives status flags, and buffers up to two results in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Feeds the writeback / branch-resolve logic.
- Includes a saturating back-pressure (stall) counter for performance debug.

Parameters:
- WIDTH, 32, datapath width of all unit results and of result.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents an operation this cycle
- in_ready  output  1  stage can accept an operation this cycle
- unit_sel  input  2  result source: 00 bool, 01 arith, 10 shift, 11 compare
- bool_in  input  WIDTH  boolean unit result
- arith_in  input  WIDTH  add/sub unit result
- arith_ovf  input  1  signed overflow from add/sub unit
- arith_cout  input  1  carry-out from add/sub unit
- shift_in  input  WIDTH  shifter result
- cmp_in  input  1  set-less-than result bit
- out_valid  output  1  result and flags at FIFO head are valid
- out_ready  input  1  downstream consumes the head this cycle
- result  output  WIDTH  selected result (FIFO head)
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- overflow  output  1  arith_ovf when unit_sel==01, else 0
- carry  output  1  arith_cout when unit_sel==01, else 0
- stat_clr  input  1  synchronous clear of stall_cnt
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Data and unit_sel must be stable only in the accept cycle.
- Selection:
  - Compare result = {(WIDTH-1){0}, cmp_in}.
  - zero and negative are computed from the selected value at push time and stored alongside it.
  - overflow and carry are forced to 0 for non-arith sources.
- FIFO:
  - 2 entries, count 0..2, write pointer and read pointer each 1 bit and wrapping.
  - in_ready is a function of the count register only (in_ready = count != 2). There is no combinational path from out_ready.
  - out_valid = count != 0. result and flags come from the head entry.
- Latency: an operation accepted at edge N is visible on the outputs after edge N (1 cycle), provided the FIFO was empty.
- Count updates:
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop together: count unchanged. This is legal only at count 1, since count 2 implies in_ready=0 and count 0 implies no pop.
- Back-to-back throughput: 1 operation per cycle while out_ready=1.
- Back-pressure:
  - Head entry and flags hold stable while out_valid && !out_ready.
  - A full FIFO deasserts in_ready the cycle after the second push.
- stall_cnt:
  - Increments when out_valid && !out_ready.
  - Saturates at all-ones.
  - stat_clr has priority: stall_cnt goes to 0 on that edge even if a stall is present.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - result=0, zero=0, negative=0, overflow=0, carry=0, stall_cnt=0.
  - In-flight entries are discarded.
  - Storage contents need not be cleared, but outputs must read 0 while count=0.

Decomposition:
- Package alu_pkg:
  - WIDTH default constant.
  - unit_sel_e enum (SEL_BOOL, SEL_ARITH, SEL_SHIFT, SEL_CMP).
  - alu_flags_t packed struct {zero, negative, overflow, carry}.
  - alu_entry_t packed struct {result, alu_flags_t}.
- Sub-module result_fifo2:
  - Generic 2-entry FIFO of alu_entry_t, with count, pointers, in_ready and out_valid.
- Top level holds:
  - Source mux and flag generation in front of result_fifo2.
  - Stall counter.

Test Plan:
- Reset, then push unit_sel=00, bool_in=0x0000_0000, out_ready=1 -> after 1 cycle out_valid=1, result=0, zero=1, negative=0, overflow=0, carry=0; next cycle out_valid=0.
- Push arith arith_in=0x8000_0000, arith_ovf=1, arith_cout=1, then shift shift_in=0x8000_0000 with ovf/cout still 1 -> first: negative=1, overflow=1, carry=1; second: negative=1, overflow=0, carry=0.
- Compare cmp_in=1 -> result=0x0000_0001, zero=0; cmp_in=0 -> result=0, zero=1.
- Hold out_ready=0, push 0x11 and 0x22 -> in_ready=0 after the second push; a third in_valid is not accepted; stall_cnt counts up; raise out_ready -> 0x11 then 0x22 in order, in_ready returns to 1.
- Stream 8 ops with in_valid=out_ready=1 every cycle -> 8 results on consecutive cycles, in order, count never exceeds 1; then force out_ready=0 for 2^16+3 cycles -> stall_cnt=0xFFFF; pulse stat_clr during the stall -> stall_cnt=0.
- Assert reset asynchronously (mid-cycle) with 2 entries held -> out_valid=0, in_ready=1, result=0 and flags=0 immediately, before the next clk edge; after release a new push yields only the new value.
